// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state encoding and constants for the PC sequencer.
package pc_seq_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, TRAP} pc_state_t;
    localparam logic [31:0] INSTR_BYTES   = 32'd4;
    localparam logic [31:0] JALR_LSB_MASK = 32'hFFFF_FFFE;
endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational next-PC adder with operand muxes, jalr bit-0 clear and alignment check.
module next_pc_calc
    import pc_seq_pkg::*;
(
    input  logic        a_src_i,
    input  logic        b_src_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_val_i,
    input  logic [31:0] imm_i,
    output logic [31:0] target_o,
    output logic        misaligned_o
);
    logic [31:0] sum;
    assign sum          = (a_src_i ? rs1_val_i : pc_i) + (b_src_i ? imm_i : INSTR_BYTES);
    assign target_o     = a_src_i ? (sum & JALR_LSB_MASK) : sum;
    assign misaligned_o = |target_o[1:0];
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC, fetches through the imem handshake and commits the next PC on exec_done.
// Define PC_SEQ_MISALIGN_TRAP_EN to trap on misaligned targets instead of truncating them.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        nxt_a_src,
    input  logic        nxt_b_src,
    input  logic [31:0] rs1_val,
    input  logic [31:0] imm,
    input  logic        exec_done,
    output logic [31:0] instret
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    ,
    output logic        trap
`endif
);
    pc_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, instret_q, instret_d, target;
    logic        misaligned;

    next_pc_calc u_calc (
        .a_src_i      (nxt_a_src),
        .b_src_i      (nxt_b_src),
        .pc_i         (pc_q),
        .rs1_val_i    (rs1_val),
        .imm_i        (imm),
        .target_o     (target),
        .misaligned_o (misaligned)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        instret_d = instret_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: if (imem_ack) begin
                instr_d = imem_rdata;
                state_d = EXEC;
            end
            EXEC: if (exec_done) begin
`ifdef PC_SEQ_MISALIGN_TRAP_EN
                if (misaligned) begin
                    state_d = TRAP;
                end else begin
                    pc_d      = target;
                    instret_d = instret_q + 32'd1;
                    state_d   = FETCH;
                end
`else
                // Low address bits are dropped rather than trapped on.
                pc_d      = misaligned ? {target[31:2], 2'b00} : target;
                instret_d = instret_q + 32'd1;
                state_d   = FETCH;
`endif
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            pc_q      <= RESET_VEC;
            instr_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            instret_q <= instret_d;
        end
    end

    assign imem_req    = state_q == FETCH;
    assign instr_valid = state_q == EXEC;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + INSTR_BYTES;
    assign instr       = instr_q;
    assign instret     = instret_q;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    assign trap        = state_q == TRAP;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized self-checking bench against an arithmetic reference model.
// Adapts its expectations to PC_SEQ_MISALIGN_TRAP_EN.
module tb_pc_sequencer;
    localparam logic [31:0] RV = 32'h100;

    logic        clk = 0, rstn = 0;
    logic        imem_req, imem_ack = 0, instr_valid, nxt_a_src = 0, nxt_b_src = 0, exec_done = 0;
    logic [31:0] imem_addr, imem_rdata = 0, instr, pc, pc_plus4, rs1_val = 0, imm = 0, instret;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    logic        trap;
`endif

    int          n_checks = 0, n_pass = 0;
    logic [31:0] m_pc, m_instret;
    bit          m_trap = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_VEC(RV)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .nxt_a_src   (nxt_a_src),
        .nxt_b_src   (nxt_b_src),
        .rs1_val     (rs1_val),
        .imm         (imm),
        .exec_done   (exec_done),
        .instret     (instret)
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        ,
        .trap        (trap)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input int ack_wait, input logic [31:0] word, input bit a, input bit b,
                             input logic [31:0] rs1, input logic [31:0] imm_v, input int exec_wait);
        logic [31:0] t;
        for (int i = 0; i < ack_wait; i++) begin
            imem_ack  = 0;
            exec_done = 1'($urandom_range(0, 1));
            nxt_a_src = 1'($urandom_range(0, 1));
            rs1_val   = $urandom;
            tick;
            check("stall_req", 32'(imem_req), 32'd1);
            check("stall_addr", imem_addr, m_pc);
            check("stall_valid", 32'(instr_valid), 32'd0);
            check("stall_pc", pc, m_pc);
        end
        exec_done  = 0;
        imem_ack   = 1;
        imem_rdata = word;
        tick;
        imem_ack   = 0;
        imem_rdata = $urandom;
        check("fetch_valid", 32'(instr_valid), 32'd1);
        check("fetch_instr", instr, word);
        check("fetch_req", 32'(imem_req), 32'd0);
        for (int i = 0; i < exec_wait; i++) begin
            imem_ack  = 1'($urandom_range(0, 1));
            nxt_a_src = 1'($urandom_range(0, 1));
            nxt_b_src = 1'($urandom_range(0, 1));
            imm       = $urandom;
            tick;
            check("exec_instr", instr, word);
            check("exec_valid", 32'(instr_valid), 32'd1);
            check("exec_pc", pc, m_pc);
        end
        imem_ack  = 0;
        nxt_a_src = a;
        nxt_b_src = b;
        rs1_val   = rs1;
        imm       = imm_v;
        exec_done = 1;
        tick;
        exec_done = 0;
        t = (a ? rs1 : m_pc) + (b ? imm_v : 32'd4);
        if (a) t = t - t % 2;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        if (t % 4 != 0) m_trap = 1;
        else begin
            m_pc = t;
            m_instret++;
        end
        check("trap", 32'(trap), 32'(m_trap));
`else
        m_pc = t - t % 4;
        m_instret++;
`endif
        check("commit_pc", pc, m_pc);
        check("commit_pc_plus4", pc_plus4, m_pc + 32'd4);
        check("commit_instret", instret, m_instret);
        check("commit_req", 32'(imem_req), m_trap ? 32'd0 : 32'd1);
        check("commit_valid", 32'(instr_valid), 32'd0);
    endtask

    initial begin
        #12;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, RV);
        check("rst_pc", pc, RV);
        check("rst_pc_plus4", pc_plus4, RV + 32'd4);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instret", instret, 32'd0);
        tick;
        check("rst_hold_req", 32'(imem_req), 32'd0);
        rstn = 1;
        m_pc = RV;
        m_instret = 0;
        check("idle_req", 32'(imem_req), 32'd0);
        tick;
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, RV);

        run_instr(0, 32'h13, 1, 1, 32'h200, 32'h0, 0);
        run_instr(1, $urandom, 0, 0, 32'h0, 32'h0, 1);
        check("seq_pc", pc, 32'h204);
        run_instr(5, $urandom, 1, 1, 32'h300, 32'h0, 2);
        run_instr(0, $urandom, 0, 1, 32'h0, 32'hFFFF_FFF8, 0);
        check("branch_pc", pc, 32'h2F8);
        run_instr(0, $urandom, 1, 1, 32'h1001, 32'h4, 0);
        check("jalr_pc", pc, 32'h1004);
        run_instr(0, $urandom, 1, 1, 32'hFFFF_FFFC, 32'h0, 0);
        run_instr(2, $urandom, 0, 0, 32'h0, 32'h0, 0);
        check("wrap_pc", pc, 32'h0);

        for (int k = 0; k < 40; k++)
            run_instr(int'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom & ~32'h2, $urandom & ~32'h3,
                      int'($urandom_range(0, 2)));

        imem_ack = 0;
        tick;
        check("prereset_req", 32'(imem_req), 32'd1);
        rstn = 0;
        #1;
        check("midrst_req", 32'(imem_req), 32'd0);
        check("midrst_pc", pc, RV);
        check("midrst_valid", 32'(instr_valid), 32'd0);
        check("midrst_instret", instret, 32'd0);
        m_pc = RV;
        m_instret = 0;
        tick;
        rstn = 1;
        tick;
        check("refetch_req", 32'(imem_req), 32'd1);
        check("refetch_addr", imem_addr, RV);

        run_instr(0, $urandom, 1, 1, 32'h400, 32'h0, 0);
        run_instr(0, $urandom, 0, 1, 32'h0, 32'h2, 0);
        check("misalign_pc", pc, 32'h400);
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        for (int i = 0; i < 4; i++) begin
            imem_ack  = 1;
            exec_done = 1;
            tick;
            check("trap_req", 32'(imem_req), 32'd0);
            check("trap_valid", 32'(instr_valid), 32'd0);
            check("trap_sticky", 32'(trap), 32'd1);
            check("trap_pc", pc, 32'h400);
        end
        imem_ack  = 0;
        exec_done = 0;
`else
        check("misalign_req", 32'(imem_req), 32'd1);
        run_instr(1, $urandom, 0, 0, 32'h0, 32'h0, 0);
        check("after_misalign_pc", pc, 32'h404);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
